// File: rtl/count_sequence_checker.sv
// Observer for a free-running binary counter: locks onto a +1 (mod 2^WIDTH) sequence,
// then reports steps, wrap-arounds, stalls and sequence errors.
module count_sequence_checker #(
    parameter int WIDTH    = 3,
    parameter int SYNC_LEN = 2,
    parameter int HOLD_MAX = 4,
    parameter int WRAPW    = 8
) (
    input  logic             CK,
    input  logic             CLR,
    input  logic             EN,
    input  logic [WIDTH-1:0] CNT,
    output logic             LOCK,
    output logic             STEP,
    output logic [WRAPW-1:0] WRAPS,
    output logic             STALL,
    output logic             ERR,
    output logic [7:0]       ERR_CNT
);

    typedef enum logic [1:0] {IDLE, SYNC, TRACK} state_t;

    localparam logic [WIDTH-1:0] CNT_MAX = '1;

    state_t           state, state_next;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic [3:0]       good;
    logic [7:0]       hold;
    logic [7:0]       hold_inc;
    logic             is_hold, is_good, sync_done;
    logic             step_q, stall_q, err_q;
    logic [7:0]       err_cnt_q;
    logic [WRAPW-1:0] wraps_q;

    // Modular difference classifies each sample as hold, good step or bad step.
    assign delta     = CNT - prev;
    assign is_hold   = (delta == '0);
    assign is_good   = (delta == WIDTH'(1));
    assign sync_done = ((good + 4'd1) == 4'(SYNC_LEN));
    assign hold_inc  = (hold == 8'hFF) ? hold : hold + 8'd1;

    always_ff @(posedge CK) begin
        if (CLR) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (EN) begin
            case (state)
                IDLE:    state_next = SYNC;
                SYNC:    if (is_good && sync_done) state_next = TRACK;
                TRACK:   if (!is_good && !is_hold) state_next = SYNC;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (CLR) begin
            prev      <= '0;
            good      <= '0;
            hold      <= '0;
            step_q    <= 1'b0;
            stall_q   <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            wraps_q   <= '0;
        end else begin
            step_q <= 1'b0;
            if (EN) begin
                case (state)
                    IDLE: begin
                        prev <= CNT;
                        good <= '0;
                    end
                    SYNC: begin
                        if (is_good) begin
                            good <= good + 4'd1;
                            prev <= CNT;
                        end else if (!is_hold) begin
                            good <= '0;
                            prev <= CNT;
                        end
                    end
                    TRACK: begin
                        if (is_good) begin
                            step_q  <= 1'b1;
                            prev    <= CNT;
                            hold    <= '0;
                            stall_q <= 1'b0;
                            if (prev == CNT_MAX && CNT == '0) wraps_q <= wraps_q + 1'b1;
                        end else if (is_hold) begin
                            hold <= hold_inc;
                            if (hold_inc >= 8'(HOLD_MAX)) stall_q <= 1'b1;
                        end else begin
                            // Losing sequence drops back to SYNC; the error record is sticky.
                            err_q   <= 1'b1;
                            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                            stall_q <= 1'b0;
                            good    <= '0;
                            hold    <= '0;
                            prev    <= CNT;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        LOCK    = (state == TRACK);
        STEP    = step_q;
        STALL   = stall_q;
        ERR     = err_q;
        ERR_CNT = err_cnt_q;
        WRAPS   = wraps_q;
    end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Directed self-checking bench for count_sequence_checker with default parameters
// (WIDTH=3, SYNC_LEN=2, HOLD_MAX=4, WRAPW=8).
module tb_count_sequence_checker;

    logic       CK;
    logic       CLR;
    logic       EN;
    logic [2:0] CNT;
    logic       LOCK;
    logic       STEP;
    logic [7:0] WRAPS;
    logic       STALL;
    logic       ERR;
    logic [7:0] ERR_CNT;

    int errors = 0;
    int checks = 0;
    logic [2:0] c;

    count_sequence_checker dut (
        .CK(CK), .CLR(CLR), .EN(EN), .CNT(CNT),
        .LOCK(LOCK), .STEP(STEP), .WRAPS(WRAPS),
        .STALL(STALL), .ERR(ERR), .ERR_CNT(ERR_CNT)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    task automatic applyStimulus(input logic clr, input logic en, input logic [2:0] cnt);
        CLR = clr;
        EN  = en;
        CNT = cnt;
        @(posedge CK);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic lock, input logic step,
                            input logic [7:0] wraps, input logic stall,
                            input logic err, input logic [7:0] err_cnt);
        checkOutput({tag, ".lock"},    32'(LOCK),    32'(lock));
        checkOutput({tag, ".step"},    32'(STEP),    32'(step));
        checkOutput({tag, ".wraps"},   32'(WRAPS),   32'(wraps));
        checkOutput({tag, ".stall"},   32'(STALL),   32'(stall));
        checkOutput({tag, ".err"},     32'(ERR),     32'(err));
        checkOutput({tag, ".err_cnt"}, 32'(ERR_CNT), 32'(err_cnt));
    endtask

    initial begin
        CLR = 1'b1;
        EN  = 1'b0;
        CNT = 3'd0;

        applyStimulus(1'b1, 1'b1, 3'd5);
        checkAll("reset", 0, 0, 0, 0, 0, 0);

        // Lock-up: load 0, steps 1 and 2 lock on the third edge
        applyStimulus(1'b0, 1'b1, 3'd0);
        checkAll("load", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd1);
        checkAll("sync1", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd2);
        checkAll("lock_edge", 1, 0, 0, 0, 0, 0);
        for (int v = 3; v <= 7; v++) begin
            applyStimulus(1'b0, 1'b1, 3'(v));
            checkAll($sformatf("count%0d", v), 1, 1, 0, 0, 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 3'd0);
        checkAll("wrap1", 1, 1, 1, 0, 0, 0);
        for (int v = 1; v <= 5; v++) begin
            applyStimulus(1'b0, 1'b1, 3'(v));
            checkOutput($sformatf("run%0d.step", v), 32'(STEP), 32'd1);
        end

        // Stall: hold at 5, STALL on the 4th hold edge
        for (int h = 1; h <= 3; h++) begin
            applyStimulus(1'b0, 1'b1, 3'd5);
            checkAll($sformatf("hold%0d", h), 1, 0, 1, 0, 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 3'd5);
        checkAll("hold4", 1, 0, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd5);
        checkAll("hold5", 1, 0, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd6);
        checkAll("unstall", 1, 1, 1, 0, 0, 0);

        // Stall at 7, then the 7->0 step both wraps and clears STALL
        applyStimulus(1'b0, 1'b1, 3'd7);
        for (int h = 1; h <= 4; h++) applyStimulus(1'b0, 1'b1, 3'd7);
        checkAll("stall7", 1, 0, 1, 1, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd0);
        checkAll("wrap_unstall", 1, 1, 2, 0, 0, 0);

        // Sequence error at 3 -> 6, relock via 7, 0 (wrap in SYNC not counted)
        applyStimulus(1'b0, 1'b1, 3'd1);
        applyStimulus(1'b0, 1'b1, 3'd2);
        applyStimulus(1'b0, 1'b1, 3'd3);
        checkAll("at3", 1, 1, 2, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd6);
        checkAll("jump", 0, 0, 2, 0, 1, 1);
        applyStimulus(1'b0, 1'b1, 3'd7);
        checkAll("resync7", 0, 0, 2, 0, 1, 1);
        applyStimulus(1'b0, 1'b1, 3'd0);
        checkAll("relock0", 1, 0, 2, 0, 1, 1);

        // Bad steps in SYNC never set ERR; good count restarts at 4
        applyStimulus(1'b1, 1'b1, 3'd3);
        checkAll("clr2", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd0);
        applyStimulus(1'b0, 1'b1, 3'd1);
        applyStimulus(1'b0, 1'b1, 3'd4);
        checkAll("sync_bad", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd5);
        checkAll("sync_5", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd6);
        checkAll("sync_lock6", 1, 0, 0, 0, 0, 0);

        // EN=0 freezes everything while CNT wanders
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 3'((k * 3 + 1) % 8));
            checkAll($sformatf("frozen%0d", k), 1, 0, 0, 0, 0, 0);
        end
        applyStimulus(1'b0, 1'b1, 3'd7);
        checkAll("thaw", 1, 1, 0, 0, 0, 0);

        // Repeated bad steps with relock: ERR_CNT saturates at 255
        c = 3'd7;
        for (int i = 0; i < 255; i++) begin
            c = c + 3'd3;
            applyStimulus(1'b0, 1'b1, c);
            c = c + 3'd1;
            applyStimulus(1'b0, 1'b1, c);
            c = c + 3'd1;
            applyStimulus(1'b0, 1'b1, c);
        end
        checkAll("errs255", 1, 0, 0, 0, 1, 255);
        for (int i = 0; i < 45; i++) begin
            c = c + 3'd3;
            applyStimulus(1'b0, 1'b1, c);
            c = c + 3'd1;
            applyStimulus(1'b0, 1'b1, c);
            c = c + 3'd1;
            applyStimulus(1'b0, 1'b1, c);
        end
        checkAll("errs300", 1, 0, 0, 0, 1, 255);
        c = c + 3'd2;
        applyStimulus(1'b0, 1'b1, c);
        checkAll("err_sat", 0, 0, 0, 0, 1, 255);

        // CLR wins over a simultaneous step; block restarts from IDLE
        applyStimulus(1'b1, 1'b1, c + 3'd1);
        checkAll("clr_mid", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd4);
        checkAll("idle_load", 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 1'b1, 3'd5);
        checkOutput("after_clr_sync.lock", 32'(LOCK), 32'd0);
        applyStimulus(1'b0, 1'b1, 3'd6);
        checkOutput("after_clr_lock.lock", 32'(LOCK), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
